// File: rtl/bj_redirect_if.sv
// Branch/jump resolution bus between the EX stage and the redirect controller.
interface bj_redirect_if;
  localparam int unsigned XLEN = 32;

  logic            bj_valid;
  logic [2:0]      branch_jump;
  logic            pc_sel;
  logic            predict_taken;
  logic [XLEN-1:0] target_pc;
  logic [XLEN-1:0] pc_plus4;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            flush_ifid;
  logic            flush_idex;

  // EX stage side: presents the resolution, consumes redirect and flushes.
  modport master (
    output bj_valid, branch_jump, pc_sel, predict_taken, target_pc, pc_plus4,
    input  redirect, redirect_pc, flush_ifid, flush_idex
  );

  // Controller side.
  modport slave (
    input  bj_valid, branch_jump, pc_sel, predict_taken, target_pc, pc_plus4,
    output redirect, redirect_pc, flush_ifid, flush_idex
  );
endinterface

// File: rtl/bj_redirect_ctrl.sv
// Redirect/flush sequencer for EX-stage branch and jump resolution,
// with saturating branch and mispredict statistics.
module bj_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             cnt_clear,
  bj_redirect_if.slave     bj,
  output logic             busy,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int unsigned FCNT_W = 4;
  localparam int unsigned XLEN   = 32;
  localparam logic [2:0]  BJ_NONE = 3'b010;

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              redirect_q, redirect_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              flush_q, flush_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;
  logic [CNT_W-1:0]  mcnt_q, mcnt_d;

  logic              accept_c;
  logic              mispred_c;
  logic [XLEN-1:0]   sel_pc_c;
  logic [XLEN-1:0]   next_pc_c;

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Resolution decode: accept only fresh, un-stalled, real branches in IDLE.
  always_comb begin
    accept_c  = (state_q == IDLE) && bj.bj_valid && !stall && (bj.branch_jump != BJ_NONE);
    mispred_c = bj.pc_sel ^ bj.predict_taken;
    sel_pc_c  = bj.pc_sel ? bj.target_pc : bj.pc_plus4;
    next_pc_c = sel_pc_c & ~XLEN'(1);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    redirect_d    = redirect_q;
    redirect_pc_d = redirect_pc_q;
    flush_d       = flush_q;
    bcnt_d        = bcnt_q;
    mcnt_d        = mcnt_q;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          bcnt_d = sat_inc(bcnt_q);
          if (mispred_c) begin
            mcnt_d        = sat_inc(mcnt_q);
            state_d       = FLUSH;
            fcnt_d        = FCNT_W'(FLUSH_CYCLES);
            redirect_d    = 1'b1;
            redirect_pc_d = next_pc_c;
            flush_d       = 1'b1;
          end
        end
      end
      FLUSH: begin
        // A stalled cycle freezes everything so fetch still sees the redirect.
        if (!stall) begin
          redirect_d = 1'b0;
          fcnt_d     = fcnt_q - FCNT_W'(1);
          if (fcnt_q == FCNT_W'(1)) begin
            flush_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear has priority over a same-edge increment.
    if (cnt_clear) begin
      bcnt_d = '0;
      mcnt_d = '0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      fcnt_q        <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
      busy_q        <= 1'b0;
      bcnt_q        <= '0;
      mcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      flush_q       <= flush_d;
      busy_q        <= busy_d;
      bcnt_q        <= bcnt_d;
      mcnt_q        <= mcnt_d;
    end
  end

  assign bj.redirect    = redirect_q;
  assign bj.redirect_pc = redirect_pc_q;
  assign bj.flush_ifid  = flush_q;
  assign bj.flush_idex  = flush_q;
  assign busy           = busy_q;
  assign branch_count   = bcnt_q;
  assign mispred_count  = mcnt_q;

endmodule

// File: tb/tb_bj_redirect_ctrl.sv
// Bench for bj_redirect_ctrl: directed vector table, hand sequences for
// saturation and reset-in-flush, then random traffic against a model.
module tb_bj_redirect_ctrl;

  localparam int unsigned FC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, cnt_clear;
  logic        v_valid, v_sel, v_pred;
  logic [2:0]  v_bj;
  logic [31:0] v_tgt, v_pc4;

  logic        busy16, busy4;
  logic [15:0] bc16, mc16;
  logic [3:0]  bc4, mc4;

  bj_redirect_if if16 ();
  bj_redirect_if if4 ();

  assign if16.bj_valid = v_valid;  assign if4.bj_valid = v_valid;
  assign if16.branch_jump = v_bj;  assign if4.branch_jump = v_bj;
  assign if16.pc_sel = v_sel;      assign if4.pc_sel = v_sel;
  assign if16.predict_taken = v_pred; assign if4.predict_taken = v_pred;
  assign if16.target_pc = v_tgt;   assign if4.target_pc = v_tgt;
  assign if16.pc_plus4 = v_pc4;    assign if4.pc_plus4 = v_pc4;

  bj_redirect_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(16)) dut16 (
    .clk(clk), .reset(reset), .stall(stall), .cnt_clear(cnt_clear), .bj(if16),
    .busy(busy16), .branch_count(bc16), .mispred_count(mc16)
  );

  bj_redirect_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .cnt_clear(cnt_clear), .bj(if4),
    .busy(busy4), .branch_count(bc4), .mispred_count(mc4)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: flush window length, redirect pending, unbounded counts.
  int          m_left;
  bit          m_red;
  logic [31:0] m_pc;
  int          m_bc, m_mc;

  function automatic void model_step();
    if (reset) begin
      m_left = 0; m_red = 0; m_pc = 0; m_bc = 0; m_mc = 0;
    end else begin
      if (m_left > 0) begin
        if (!stall) begin
          m_red  = 0;
          m_left = m_left - 1;
        end
      end else if (v_valid && !stall && v_bj != 3'b010) begin
        m_bc++;
        if (v_sel != v_pred) begin
          m_mc++;
          m_left = FC;
          m_red  = 1;
          m_pc   = (v_sel ? v_tgt : v_pc4) & 32'hFFFF_FFFE;
        end
      end
      if (cnt_clear) begin
        m_bc = 0;
        m_mc = 0;
      end
    end
  endfunction

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic drive(input logic rst, input logic stl, input logic vld, input logic [2:0] bj,
                       input logic sel, input logic pred, input logic [31:0] tgt,
                       input logic [31:0] pc4, input logic clr);
    reset = rst; stall = stl; v_valid = vld; v_bj = bj; v_sel = sel; v_pred = pred;
    v_tgt = tgt; v_pc4 = pc4; cnt_clear = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic        rst, stl, vld;
    logic [2:0]  bj;
    logic        sel, pred;
    logic [31:0] tgt, pc4;
    logic        clr;
    logic        e_red;
    logic [31:0] e_pc;
    logic        e_fl;
    logic [15:0] e_bc, e_mc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic stl, input logic vld, input logic [2:0] bj,
                              input logic sel, input logic pred, input logic [31:0] tgt,
                              input logic [31:0] pc4, input logic clr, input logic e_red,
                              input logic [31:0] e_pc, input logic e_fl,
                              input logic [15:0] e_bc, input logic [15:0] e_mc);
    vec_t v;
    v.rst = rst; v.stl = stl; v.vld = vld; v.bj = bj; v.sel = sel; v.pred = pred;
    v.tgt = tgt; v.pc4 = pc4; v.clr = clr;
    v.e_red = e_red; v.e_pc = e_pc; v.e_fl = e_fl; v.e_bc = e_bc; v.e_mc = e_mc;
    return v;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_redirect"}, 32'(if16.redirect), 32'(m_red));
    if (m_red) chk({tag, "_redirect_pc"}, if16.redirect_pc, m_pc);
    chk({tag, "_flush_ifid"}, 32'(if16.flush_ifid), 32'(m_left > 0));
    chk({tag, "_flush_idex"}, 32'(if16.flush_idex), 32'(m_left > 0));
    chk({tag, "_busy"}, 32'(busy16), 32'(m_left > 0));
    chk({tag, "_branch16"}, 32'(bc16), 32'(sat(m_bc, 16)));
    chk({tag, "_mispred16"}, 32'(mc16), 32'(sat(m_mc, 16)));
    chk({tag, "_branch4"}, 32'(bc4), 32'(sat(m_bc, 4)));
    chk({tag, "_mispred4"}, 32'(mc4), 32'(sat(m_mc, 4)));
    chk({tag, "_redirect4"}, 32'(if4.redirect), 32'(m_red));
  endtask

  initial begin
    drive(1, 0, 0, 3'b010, 0, 0, 0, 0, 0);

    // rst stl vld bj     sel pred tgt           pc4           clr | red pc            fl bc mc
    tbl.push_back(mk(1, 0, 0, 3'b010, 0, 0, 32'h0,        32'h0,   0,  0, 32'h0,        0, 0, 0));
    // BEQ mispredicted not-taken -> redirect to target
    tbl.push_back(mk(0, 0, 1, 3'b000, 1, 0, 32'h100,      32'h44,  0,  1, 32'h100,      1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 3'b010, 0, 0, 32'h0,        32'h0,   0,  0, 32'h0,        1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 3'b010, 0, 0, 32'h0,        32'h0,   0,  0, 32'h0,        0, 1, 1));
    // BLTU correctly predicted taken
    tbl.push_back(mk(1, 0, 0, 3'b010, 0, 0, 32'h0,        32'h0,   0,  0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b110, 1, 1, 32'h300,      32'h80,  0,  0, 32'h0,        0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 3'b010, 0, 0, 32'h0,        32'h0,   0,  0, 32'h0,        0, 1, 0));
    // BNE mispredicted taken, three stalled cycles after accept
    tbl.push_back(mk(1, 0, 0, 3'b010, 0, 0, 32'h0,        32'h0,   0,  0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b001, 0, 1, 32'h999,      32'h204, 0,  1, 32'h204,      1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 3'b010, 0, 0, 32'h0,        32'h0,   0,  1, 32'h204,      1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 3'b010, 0, 0, 32'h0,        32'h0,   0,  1, 32'h204,      1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 3'b010, 0, 0, 32'h0,        32'h0,   0,  1, 32'h204,      1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 3'b010, 0, 0, 32'h0,        32'h0,   0,  0, 32'h0,        1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 3'b010, 0, 0, 32'h0,        32'h0,   0,  0, 32'h0,        0, 1, 1));
    // 010 ignored, stalled BEQ counted once on release
    tbl.push_back(mk(1, 0, 0, 3'b010, 0, 0, 32'h0,        32'h0,   0,  0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b010, 1, 0, 32'h500,      32'h10,  0,  0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 3'b000, 0, 0, 32'h500,      32'h10,  0,  0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 3'b000, 0, 0, 32'h500,      32'h10,  0,  0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 3'b000, 0, 0, 32'h500,      32'h10,  0,  0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 3'b000, 0, 0, 32'h500,      32'h10,  0,  0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b000, 0, 0, 32'h500,      32'h10,  0,  0, 32'h0,        0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 3'b010, 0, 0, 32'h0,        32'h0,   0,  0, 32'h0,        0, 1, 0));
    // JALR to odd target clears bit 0; branch in flush is wrong-path
    tbl.push_back(mk(1, 0, 0, 3'b010, 0, 0, 32'h0,        32'h0,   0,  0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b011, 1, 0, 32'h403,      32'h20,  0,  1, 32'h402,      1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 3'b000, 1, 0, 32'h800,      32'h24,  0,  0, 32'h0,        1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 3'b000, 1, 0, 32'h800,      32'h24,  0,  0, 32'h0,        0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 3'b010, 0, 0, 32'h0,        32'h0,   0,  0, 32'h0,        0, 1, 1));
    // clear beats same-edge accept, then counting resumes
    tbl.push_back(mk(0, 0, 1, 3'b100, 0, 0, 32'h0,        32'h30,  1,  0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3'b101, 1, 1, 32'h40,       32'h34,  0,  0, 32'h0,        0, 1, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].stl, tbl[i].vld, tbl[i].bj, tbl[i].sel, tbl[i].pred,
            tbl[i].tgt, tbl[i].pc4, tbl[i].clr);
      tick();
      chk($sformatf("vec%0d_redirect", i), 32'(if16.redirect), 32'(tbl[i].e_red));
      if (tbl[i].e_red) chk($sformatf("vec%0d_redirect_pc", i), if16.redirect_pc, tbl[i].e_pc);
      chk($sformatf("vec%0d_flush_ifid", i), 32'(if16.flush_ifid), 32'(tbl[i].e_fl));
      chk($sformatf("vec%0d_flush_idex", i), 32'(if16.flush_idex), 32'(tbl[i].e_fl));
      chk($sformatf("vec%0d_busy", i), 32'(busy16), 32'(tbl[i].e_fl));
      chk($sformatf("vec%0d_branch", i), 32'(bc16), 32'(tbl[i].e_bc));
      chk($sformatf("vec%0d_mispred", i), 32'(mc16), 32'(tbl[i].e_mc));
      chk($sformatf("vec%0d_branch4", i), 32'(bc4), 32'(tbl[i].e_bc));
    end

    // Saturation: 17 accepted mispredicts; the 4-bit counters stick at 0xF.
    drive(1, 0, 0, 3'b010, 0, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 17; k++) begin
      drive(0, 0, 1, 3'b000, 1, 0, 32'h1000 + 32'(k * 16), 32'h4, 0);
      tick();
      drive(0, 0, 0, 3'b010, 0, 0, 0, 0, 0);
      tick();
      tick();
      if (k == 15) begin
        chk("sat16_branch4", 32'(bc4), 32'hF);
        chk("sat16_mispred4", 32'(mc4), 32'hF);
        chk("sat16_branch16", 32'(bc16), 32'd16);
      end
    end
    chk("sat17_branch4", 32'(bc4), 32'hF);
    chk("sat17_mispred4", 32'(mc4), 32'hF);
    chk("sat17_mispred16", 32'(mc16), 32'd17);

    // Reset landing in the middle of a flush window.
    drive(0, 0, 1, 3'b111, 0, 1, 32'h0, 32'h600, 0);
    tick();
    chk("preflush_busy", 32'(busy16), 32'd1);
    drive(1, 0, 0, 3'b010, 0, 0, 0, 0, 0);
    tick();
    chk("rstflush_redirect", 32'(if16.redirect), 32'd0);
    chk("rstflush_redirect_pc", if16.redirect_pc, 32'd0);
    chk("rstflush_flush", 32'({if16.flush_ifid, if16.flush_idex}), 32'd0);
    chk("rstflush_busy", 32'(busy16), 32'd0);
    chk("rstflush_counts", 32'({bc16, mc16}), 32'd0);
    chk("rstflush_counts4", 32'({bc4, mc4}), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
            3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom, $urandom, ($urandom_range(0, 199) == 0));
      tick();
      check_model("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
